// File: rtl/multicore_pkg.sv
// multicore_pkg: shared core sizes and pipeline control encodings
package multicore_pkg;
  localparam int DATA_SIZE = 32;
  localparam int INST_SIZE = 32;
  localparam int NUM_REGS  = 32;
  localparam int REG_AW    = $clog2(NUM_REGS);
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC = 2'b10, WB_RSVD = 2'b11} t_wbsel;
  typedef enum logic [2:0] {LD_B, LD_H, LD_W, LD_BU, LD_HU} t_ldop;
  typedef enum logic [1:0] {SOP_B, SOP_H, SOP_W} t_sop;
endpackage

// File: rtl/reg_file.sv
// reg_file: NUM_REGS x DATA_SIZE registers; ports: i_aclk/i_areset_n, one write port (we_i, waddr_i, wdata_i), NUM_RD_PORTS async read ports (raddr_i -> rdata_o) with x0 = 0 and write bypass
module reg_file import multicore_pkg::*; #(
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                                   i_aclk,
  input  logic                                   i_areset_n,
  input  logic                                   we_i,
  input  logic [REG_AW-1:0]                      waddr_i,
  input  logic [DATA_SIZE-1:0]                   wdata_i,
  input  logic [NUM_RD_PORTS-1:0][REG_AW-1:0]    raddr_i,
  output logic [NUM_RD_PORTS-1:0][DATA_SIZE-1:0] rdata_o
);
  logic [DATA_SIZE-1:0] regs_q [NUM_REGS];
  always_ff @(posedge i_aclk or negedge i_areset_n)
    if (!i_areset_n) for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    else if (we_i && waddr_i != '0) regs_q[waddr_i] <= wdata_i;
  for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_rd
    assign rdata_o[g] = (raddr_i[g] == '0) ? '0 :
                        (we_i && raddr_i[g] == waddr_i) ? wdata_i : regs_q[raddr_i[g]];
  end
endmodule

// File: rtl/write_back.sv
// write_back: selects write-back data, waits on pending loads, commits to reg_file; ports: control/data in, rs1/rs2 reads, o_stall, forwarding view, 64-bit commit count
module write_back import multicore_pkg::*; #(
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                 i_aclk,
  input  logic                 i_areset_n,
  input  logic                 i_cu_regwrite,
  input  logic [1:0]           i_cu_memtoreg,
  input  logic [REG_AW-1:0]    i_rdest,
  input  logic [DATA_SIZE-1:0] i_exe_data,
  input  logic [DATA_SIZE-1:0] i_mem_data,
  input  logic                 i_mem_valid,
  input  logic [INST_SIZE-1:0] i_pcplus4,
  input  logic [REG_AW-1:0]    i_rs1_addr,
  input  logic [REG_AW-1:0]    i_rs2_addr,
  output logic [DATA_SIZE-1:0] o_rs1_data,
  output logic [DATA_SIZE-1:0] o_rs2_data,
  output logic                 o_stall,
  output logic                 o_fwd_valid,
  output logic [REG_AW-1:0]    o_fwd_rdest,
  output logic [DATA_SIZE-1:0] o_fwd_data,
  output logic [63:0]          o_commit_count
);
  typedef enum logic {WB_IDLE, WB_LDWAIT} t_wb_state;
  t_wb_state state_q, state_d;
  logic [REG_AW-1:0] rdest_q, rdest_d, waddr;
  logic [DATA_SIZE-1:0] wdata, sel_data;
  logic [63:0] count_q;
  logic commit, stall, wr_en;
  logic [NUM_RD_PORTS-1:0][REG_AW-1:0] raddr;
  logic [NUM_RD_PORTS-1:0][DATA_SIZE-1:0] rdata;
  t_wbsel sel;
  assign sel = t_wbsel'(i_cu_memtoreg);
  assign sel_data = (sel == WB_MEM) ? i_mem_data : (sel == WB_PC) ? DATA_SIZE'(i_pcplus4) : i_exe_data;
  always_comb begin
    state_d = state_q;
    rdest_d = rdest_q;
    waddr   = i_rdest;
    wdata   = sel_data;
    commit  = 1'b0;
    stall   = 1'b0;
    if (state_q == WB_LDWAIT) begin
      waddr   = rdest_q;
      wdata   = i_mem_data;
      commit  = i_mem_valid;
      stall   = !i_mem_valid;
      state_d = i_mem_valid ? WB_IDLE : WB_LDWAIT;
    end else if (i_cu_regwrite) begin
      commit  = !(sel == WB_MEM && !i_mem_valid);
      stall   = !commit;
      rdest_d = commit ? rdest_q : i_rdest;
      state_d = commit ? WB_IDLE : WB_LDWAIT;
    end
  end
  // Gate with reset so nothing stalls, forwards or bypasses while held in reset
  assign wr_en   = commit & i_areset_n;
  assign o_stall = stall & i_areset_n;
  always_ff @(posedge i_aclk or negedge i_areset_n)
    if (!i_areset_n) begin
      state_q <= WB_IDLE;
      rdest_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rdest_q <= rdest_d;
      count_q <= count_q + 64'(wr_en);
    end
  assign raddr[0] = i_rs1_addr;
  assign raddr[1] = i_rs2_addr;
  reg_file #(.NUM_RD_PORTS(NUM_RD_PORTS)) u_rf (
    .i_aclk(i_aclk), .i_areset_n(i_areset_n), .we_i(wr_en), .waddr_i(waddr),
    .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rdata)
  );
  assign o_rs1_data     = rdata[0];
  assign o_rs2_data     = rdata[1];
  assign o_fwd_valid    = wr_en;
  assign o_fwd_rdest    = waddr;
  assign o_fwd_data     = wdata;
  assign o_commit_count = count_q;
endmodule

// File: doc/write_back.md
WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 SHALL have parameter NUM_RD_PORTS, default 2, number of combinational register-file read ports (fixed at 2 in this revision).
REQ-002 SHALL have port i_aclk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port i_areset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_cu_regwrite  input  1  instruction in write-back writes the register file.
REQ-005 SHALL have port i_cu_memtoreg  input  2  write-back source select, type t_wbsel.
REQ-006 SHALL have port i_rdest  input  $clog2(NUM_REGS)  destination register.
REQ-007 SHALL have port i_exe_data  input  DATA_SIZE  execution-unit result.
REQ-008 SHALL have port i_mem_data  input  DATA_SIZE  load data from data cache.
REQ-009 SHALL have port i_mem_valid  input  1  i_mem_data valid this cycle.
REQ-010 SHALL have port i_pcplus4  input  INST_SIZE  link address for JAL/JALR.
REQ-011 SHALL have ports i_rs1_addr, i_rs2_addr  input  $clog2(NUM_REGS) each  decode read addresses.
REQ-012 SHALL have ports o_rs1_data, o_rs2_data  output  DATA_SIZE each  read data.
REQ-013 SHALL have port o_stall  output  1  load pending; upstream stages hold.
REQ-014 SHALL have ports o_fwd_valid (1), o_fwd_rdest ($clog2(NUM_REGS)), o_fwd_data (DATA_SIZE)  output  value committing this cycle, for the hazard unit.
REQ-015 SHALL have port o_commit_count  output  64  number of committed register writes.

Function
REQ-016 Write data: t_wbsel WB_ALU(00) -> i_exe_data; WB_MEM(01) -> i_mem_data; WB_PC(10) -> i_pcplus4 zero-extended to DATA_SIZE; 11 reserved -> i_exe_data.
REQ-017 FSM states WB_IDLE, WB_LDWAIT; reset state WB_IDLE.
REQ-018 WB_IDLE, i_cu_regwrite=1, select not WB_MEM: commit at next edge, zero extra latency, o_stall=0.
REQ-019 WB_IDLE, i_cu_regwrite=1, WB_MEM, i_mem_valid=1: commit i_mem_data at next edge, o_stall=0.
REQ-020 WB_IDLE, i_cu_regwrite=1, WB_MEM, i_mem_valid=0: o_stall=1 combinationally the same cycle; latch i_rdest; go WB_LDWAIT; no write.
REQ-021 WB_LDWAIT: o_stall=1 while i_mem_valid=0; all other inputs ignored; in the cycle i_mem_valid=1, o_stall=0, i_mem_data is written to the latched rdest at the edge, and the FSM returns to WB_IDLE.
REQ-022 Writes to register 0 SHALL be discarded; reads of register 0 return 0.
REQ-023 Reads SHALL bypass: if a read address equals a nonzero rdest committing this cycle, the read returns the commit data.
REQ-024 o_fwd_valid=1 exactly in cycles where a commit occurs at the next edge, including rdest 0; o_fwd_data equals the write data.
REQ-025 o_commit_count SHALL increment by 1 per commit, including rdest 0, and wrap from 2^64-1 to 0.
REQ-026 i_cu_regwrite=0 SHALL cause no write, no count, and no stall.

Reset
REQ-027 Asserting i_areset_n low SHALL force FSM WB_IDLE, all registers 0, o_commit_count 0, o_stall 0, and o_fwd_valid 0.
REQ-028 Reset during WB_LDWAIT SHALL abandon the pending load with no write; a later i_mem_valid in WB_IDLE with i_cu_regwrite=0 is ignored.

Structure
REQ-029 t_wbsel and its encodings SHALL be defined in multicore_pkg beside t_ldop and t_sop; DATA_SIZE, INST_SIZE, and NUM_REGS come from that package.
REQ-030 The register array SHALL be the sub-module reg_file: 1 write port, 2 async read ports, x0 hardwired to zero, internal bypass; FSM, mux, and counter live in write_back.

Verification
REQ-031 WB_ALU, rdest=5, exe=0x12345678 -> one edge later x5=0x12345678; o_fwd_valid=1 that cycle; count=1.
REQ-032 WB_PC, rdest=1, pcplus4=0x00000104 -> x1=0x00000104.
REQ-033 WB_MEM, rdest=7, mem_valid low for 3 cycles then high with 0xDEADBEEF -> o_stall high 3 cycles, x7=0xDEADBEEF, count +1 exactly once.
REQ-034 WB_ALU, rdest=0, exe=0xFFFFFFFF -> x0 reads 0; count +1.
REQ-035 rs1_addr=9 while x9 commits 0xA5A5A5A5 -> o_rs1_data=0xA5A5A5A5 in the same cycle.
REQ-036 Reset asserted in WB_LDWAIT, then mem_valid=1 -> no write to the latched rdest; o_stall=0; count=0.
